// File: rtl/tmds_decoder.sv
// TMDS symbol decoder with word-alignment lock FSM.
// Two-stage pipeline: stage 1 classifies the symbol and removes the bit-9
// inversion, stage 2 registers the decoded outputs. The lock FSM looks at the
// stage-1 symbol so that `locked` lines up with the symbol it describes.
//
// state  | meaning
// HUNT   | looking for LOCK_RUN consecutive control tokens; times out into SLIP
// LOCKED | aligned; drops back to HUNT after MAX_DATA_RUN data symbols in a row
// SLIP   | one-cycle bitslip request, then SLIP_SETTLE symbols ignored
module tmds_decoder #(
  parameter int LOCK_RUN     = 8,
  parameter int MAX_DATA_RUN = 2048,
  parameter int SLIP_WAIT    = 4096,
  parameter int SLIP_SETTLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic       bitslip
);

  localparam int CW = $clog2(LOCK_RUN) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;
  localparam int DW = $clog2(MAX_DATA_RUN) + 1;
  localparam int SW = $clog2(SLIP_SETTLE) + 1;

  localparam logic [CW-1:0] CTRL_MAX    = CW'(LOCK_RUN);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(SLIP_WAIT - 1);
  localparam logic [DW-1:0] DATA_MAX    = DW'(MAX_DATA_RUN);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_SLIP   = 2'd2;

  logic       tok_hit;
  logic [1:0] tok_code;
  logic       s1_vld, s1_ctrl, s1_x;
  logic [1:0] s1_code;
  logic [7:0] s1_d, dec;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] ctrl_run, ctrl_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [DW-1:0] data_run, data_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic          slip_start, lock_now;

  // Control token recognition on the raw input symbol.
  always_comb begin
    tok_hit  = 1'b1;
    tok_code = 2'd0;
    case (in)
      10'b1101010100: tok_code = 2'd0;
      10'b0010101011: tok_code = 2'd1;
      10'b0101010100: tok_code = 2'd2;
      10'b1010101011: tok_code = 2'd3;
      default:        tok_hit  = 1'b0;
    endcase
  end

  // Stage 1: symbol class plus the un-inverted data word; reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_ctrl <= 1'b0;
      s1_code <= 2'd0;
      s1_x    <= 1'b0;
      s1_d    <= 8'd0;
    end else begin
      s1_vld  <= 1'b1;
      s1_ctrl <= tok_hit;
      s1_code <= tok_code;
      s1_x    <= in[8];
      s1_d    <= in[9] ? ~in[7:0] : in[7:0];
    end
  end

  // Undo the XOR/XNOR transition chain.
  always_comb begin
    dec    = 8'd0;
    dec[0] = s1_d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = s1_x ? (s1_d[i] ^ s1_d[i-1]) : ~(s1_d[i] ^ s1_d[i-1]);
  end

  // Lock FSM next-state; lock takes priority over the hunt timeout.
  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl_run;
    wait_nxt   = wait_cnt;
    data_nxt   = data_run;
    settle_nxt = settle_cnt;
    slip_start = 1'b0;
    case (state)
      ST_HUNT: begin
        if (s1_vld) begin
          if (!s1_ctrl)                ctrl_nxt = '0;
          else if (ctrl_run != CTRL_MAX) ctrl_nxt = ctrl_run + 1'b1;
          if (ctrl_nxt == CTRL_MAX) begin
            state_nxt = ST_LOCKED;
            ctrl_nxt  = '0;
            wait_nxt  = '0;
            data_nxt  = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt  = ST_SLIP;
            slip_start = 1'b1;
            ctrl_nxt   = '0;
            wait_nxt   = '0;
            settle_nxt = '0;
          end else if (wait_cnt < WAIT_LAST) begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        if (settle_cnt >= SETTLE_LAST) begin
          state_nxt  = ST_HUNT;
          ctrl_nxt   = '0;
          wait_nxt   = '0;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (s1_vld) begin
          if (s1_ctrl)                   data_nxt = '0;
          else if (data_run != DATA_MAX) data_nxt = data_run + 1'b1;
          if (data_nxt == DATA_MAX) begin
            state_nxt = ST_HUNT;
            ctrl_nxt  = '0;
            wait_nxt  = '0;
            data_nxt  = '0;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  assign lock_now = (state_nxt == ST_LOCKED);

  // Lock FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      ctrl_run   <= '0;
      wait_cnt   <= '0;
      data_run   <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      ctrl_run   <= ctrl_nxt;
      wait_cnt   <= wait_nxt;
      data_run   <= data_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Stage 2: registered outputs; cd holds the last control value across data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd      <= 8'd0;
      cd      <= 2'd0;
      vde     <= 1'b0;
      locked  <= 1'b0;
      bitslip <= 1'b0;
    end else begin
      locked  <= lock_now;
      bitslip <= slip_start;
      vde     <= s1_vld && !s1_ctrl && lock_now;
      vd      <= (!s1_vld || s1_ctrl) ? 8'd0 : dec;
      if (s1_vld && s1_ctrl) cd <= s1_code;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: expectations are queued as each symbol is
// driven and popped when that symbol reaches the outputs two cycles later.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde, locked, bitslip;
  logic [12:0] obs;

  int checks   = 0;
  int failures = 0;
  int disp     = 0;
  logic [12:0] sbq[$];

  always #5 clk = ~clk;

  tmds_decoder #(
    .LOCK_RUN(8), .MAX_DATA_RUN(16), .SLIP_WAIT(32), .SLIP_SETTLE(4)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .vd(vd), .cd(cd),
    .vde(vde), .locked(locked), .bitslip(bitslip)
  );

  assign obs = {bitslip, locked, vde, cd, vd};

  function automatic logic [12:0] pk(input logic bs, input logic lk, input logic de,
                                     input logic [1:0] c, input logic [7:0] d);
    return {bs, lk, de, c, d};
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'd0:    return 10'b1101010100;
      2'd1:    return 10'b0010101011;
      2'd2:    return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference DVI TMDS encoder with running disparity held in `disp`.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    int n1, n1q;
    logic [8:0] qm;
    logic [9:0] q;
    n1 = $countones(d);
    qm = 9'd0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    if (disp == 0 || n1q == 4) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) disp += 2 * n1q - 8;
      else       disp += 8 - 2 * n1q;
    end else if ((disp > 0 && n1q > 4) || (disp < 0 && n1q < 4)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + 8 - 2 * n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + 2 * n1q - 8;
    end
    return q;
  endfunction

  task automatic test_reset(input string tag);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL reset_%s got=%h exp=%h", tag, obs, 13'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    logic [12:0] e;
    for (int k = 0; k < 8; k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL lock sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = tok(2'd0);
      sbq.push_back(pk(1'b0, k == 7, 1'b0, 2'd0, 8'h00));
      @(negedge clk);
    end
  endtask

  task automatic test_data_decode();
    logic [9:0]  sq[$];
    logic [12:0] eq[$];
    logic [12:0] e;
    logic [1:0]  lastcd;
    sq.push_back(10'b0100000000); eq.push_back(pk(1'b0, 1'b1, 1'b1, 2'd0, 8'h00));
    sq.push_back(10'b1000000000); eq.push_back(pk(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF));
    disp = 0;
    lastcd = 2'd0;
    for (int v = 0; v < 256; v++) begin
      if (v % 8 == 0) begin
        lastcd = 2'((v / 8) % 4);
        sq.push_back(tok(lastcd)); eq.push_back(pk(1'b0, 1'b1, 1'b0, lastcd, 8'h00));
      end
      sq.push_back(tmds_enc(8'(v))); eq.push_back(pk(1'b0, 1'b1, 1'b1, lastcd, 8'(v)));
    end
    for (int k = 0; k < sq.size(); k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL decode sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = sq[k];
      sbq.push_back(eq[k]);
      @(negedge clk);
    end
  endtask

  task automatic test_broken_run();
    logic [9:0]  sq[$];
    logic [12:0] eq[$];
    logic [12:0] e;
    for (int k = 0; k < 7; k++) begin
      sq.push_back(tok(2'd2)); eq.push_back(pk(1'b0, 1'b0, 1'b0, 2'd2, 8'h00));
    end
    sq.push_back(10'b0100000000); eq.push_back(pk(1'b0, 1'b0, 1'b0, 2'd2, 8'h00));
    for (int k = 0; k < 8; k++) begin
      sq.push_back(tok(2'd0)); eq.push_back(pk(1'b0, k == 7, 1'b0, 2'd0, 8'h00));
    end
    for (int k = 0; k < sq.size(); k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL broken_run sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = sq[k];
      sbq.push_back(eq[k]);
      @(negedge clk);
    end
  endtask

  task automatic test_data_run_limit();
    logic [9:0]  sq[$];
    logic [12:0] eq[$];
    logic [12:0] e;
    for (int k = 0; k < 15; k++) begin
      sq.push_back(10'b1000000000); eq.push_back(pk(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF));
    end
    sq.push_back(tok(2'd1)); eq.push_back(pk(1'b0, 1'b1, 1'b0, 2'd1, 8'h00));
    for (int k = 0; k < 18; k++) begin
      sq.push_back(10'b1000000000);
      eq.push_back(pk(1'b0, k < 15, k < 15, 2'd1, 8'hFF));
    end
    for (int k = 0; k < sq.size(); k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL data_run sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = sq[k];
      sbq.push_back(eq[k]);
      @(negedge clk);
    end
  endtask

  task automatic test_bitslip();
    logic [12:0] e;
    for (int k = 0; k < 110; k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL bitslip sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = 10'h3E0;
      sbq.push_back(pk((k % 36) == 31, 1'b0, 1'b0, 2'd0, 8'h21));
      @(negedge clk);
    end
  endtask

  task automatic test_reset_recover();
    logic [12:0] e;
    for (int k = 0; k < 11; k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL relock_a sym=%0d got=%h exp=%h", k, obs, e); end
      end
      if (k < 8) begin
        in = tok(2'd0);
        sbq.push_back(pk(1'b0, k == 7, 1'b0, 2'd0, 8'h00));
      end else begin
        in = 10'b1000000000;
        sbq.push_back(pk(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF));
      end
      @(negedge clk);
    end
    test_reset("locked");
    for (int k = 0; k < 33; k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL slip_pre sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = 10'h3E0;
      sbq.push_back(pk(k == 31, 1'b0, 1'b0, 2'd0, 8'h21));
      @(negedge clk);
    end
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL slip_pulse got=%h exp=%h", obs, e); end
    test_reset("mid_slip");
    for (int k = 0; k < 8; k++) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL relock_b sym=%0d got=%h exp=%h", k, obs, e); end
      end
      in = tok(2'd3);
      sbq.push_back(pk(1'b0, k == 7, 1'b0, 2'd3, 8'h00));
      @(negedge clk);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL drain got=%h exp=%h", obs, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 10'd0;
    @(negedge clk);
    test_reset("initial");
    test_lock();
    test_data_decode();
    test_reset("pre_broken");
    test_broken_run();
    test_data_run_limit();
    test_reset("pre_slip");
    test_bitslip();
    test_reset("pre_recover");
    test_reset_recover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
